// File: rtl/f_ifu_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, the nop word, the default reset PC
// and the fetch-word record carried through the skid register.
package f_ifu_pkg;

  typedef enum logic [1:0] {
    IfuIdle  = 2'd0,
    IfuFetch = 2'd1,
    IfuBuf   = 2'd2
  } ifu_state_e;

  localparam logic [31:0] InstrNop = 32'h0000_0000;
  localparam logic [31:0] PcReset  = 32'h0000_3000;

  // Instruction word plus its misaligned-fetch flag.
  typedef struct packed {
    logic        exc;
    logic [31:0] word;
  } fetch_word_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/f_skid_buf.sv
// One-entry holding register for a fetch word returned while the D stage is stalled.
module f_skid_buf
  import f_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout
);

  fetch_word_t data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end else if (clear) begin
      data_q <= '0;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/f_ifu.sv
// F-stage instruction fetch unit: PC, imem request/ack handshake and the F/D register.
// Optional misaligned-fetch detection is enabled by defining F_IFU_ALIGN_CHECK_EN.
module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PcReset
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic [31:0] npc,
  output logic [31:0] pc_F,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic        valid_D,
  output logic        exc_adel_D
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_npc_q, pend_npc_d;
  logic        pend_v_q, pend_v_d;

  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;
  logic        fd_exc_q, fd_exc_d;

  logic        misalign;
  logic        fetch_hit;
  logic        avail;
  logic        req;
  logic        skid_load, skid_clear;
  fetch_word_t fetch_word, skid_word, avail_word;

`ifdef F_IFU_ALIGN_CHECK_EN
  assign misalign = pc_misaligned(pc_q);
`else
  assign misalign = 1'b0;
`endif

  // A misaligned PC never reaches memory; its "word" is a nop carrying the exception flag.
  assign fetch_word.exc  = misalign;
  assign fetch_word.word = misalign ? InstrNop : imem_rdata;

  assign fetch_hit  = (state_q == IfuFetch) && (misalign || imem_ack);
  assign avail      = fetch_hit || (state_q == IfuBuf);
  assign avail_word = (state_q == IfuBuf) ? skid_word : fetch_word;

  f_skid_buf u_skid_buf (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (fetch_word),
    .dout  (skid_word)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_npc_d = pend_npc_q;
    pend_v_d   = pend_v_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;
    fd_exc_d   = fd_exc_q;
    req        = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    unique case (state_q)
      IfuIdle: begin
        state_d = IfuFetch;
      end
      IfuFetch: begin
        req = !misalign;
        if (fetch_hit && stall_D) begin
          skid_load = 1'b1;
          state_d   = IfuBuf;
        end
      end
      IfuBuf: begin
        if (!stall_D) begin
          skid_clear = 1'b1;
        end
      end
      default: begin
        state_d = IfuIdle;
      end
    endcase

    if (!stall_D) begin
      if (avail) begin
        fd_instr_d = avail_word.word;
        fd_pc_d    = pc_q;
        fd_valid_d = 1'b1;
        fd_exc_d   = avail_word.exc;
        pc_d       = pend_v_q ? pend_npc_q : npc;
        pend_v_d   = 1'b0;
        state_d    = IfuFetch;
      end else begin
        fd_instr_d = InstrNop;
        fd_pc_d    = pc_q;
        fd_valid_d = 1'b0;
        fd_exc_d   = 1'b0;
        // The instruction leaving D may be a branch whose delay slot is still in flight:
        // remember where it points so the redirect survives the bubble.
        if (fd_valid_q && !pend_v_q) begin
          pend_npc_d = npc;
          pend_v_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IfuIdle;
      pc_q       <= RESET_PC;
      pend_npc_q <= '0;
      pend_v_q   <= 1'b0;
      fd_instr_q <= InstrNop;
      fd_pc_q    <= '0;
      fd_valid_q <= 1'b0;
      fd_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_npc_q <= pend_npc_d;
      pend_v_q   <= pend_v_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
      fd_exc_q   <= fd_exc_d;
    end
  end

  assign pc_F       = pc_q;
  assign imem_req   = req;
  assign imem_addr  = pc_q;
  assign instr_D    = fd_instr_q;
  assign pc_D       = fd_pc_q;
  assign valid_D    = fd_valid_q;
  assign exc_adel_D = fd_exc_q;

endmodule

// File: tb/tb_f_ifu.sv
// Self-checking bench for f_ifu: directed vector table, hand-written corner sequences and a
// randomized run against a program-order reference model.
module tb_f_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_D = 1'b0;
  logic [31:0] npc = 32'h0;
  logic [31:0] pc_F;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;
  logic        exc_adel_D;

  int checks = 0;
  int failures = 0;

  f_ifu dut (
    .clk        (clk),
    .reset      (reset),
    .stall_D    (stall_D),
    .npc        (npc),
    .pc_F       (pc_F),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D),
    .exc_adel_D (exc_adel_D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Program image: word contents derive from the address; 1 in 8 is a branch whose target
  // sits in the low half-word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    if (h[2:0] == 3'd0) return {16'hB000, 4'h3, h[13:4], 2'b00};
    return {8'h01, a[23:0]};
  endfunction

  function automatic logic is_br(input logic [31:0] w);
    return w[31:24] == 8'hB0;
  endfunction

  function automatic logic [31:0] br_tgt(input logic [31:0] w);
    return {16'h0, w[15:0]};
  endfunction

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pcd;
    logic [31:0] exp_instr;
  } vec_t;

  function automatic vec_t mk(input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ei,
                              input logic rst, input logic stall, input logic ack,
                              input logic [31:0] rdata, input logic [31:0] n);
    vec_t v;
    v.exp_req = er;  v.exp_addr = ea;  v.exp_valid = ev;  v.exp_pcd = epc;  v.exp_instr = ei;
    v.rst = rst;     v.stall = stall;  v.ack = ack;       v.rdata = rdata;  v.npc = n;
    return v;
  endfunction

  localparam logic [31:0] W0 = 32'h2401_0001, W1 = 32'h2402_0002, W2 = 32'h2403_0003;
  localparam logic [31:0] BR = 32'hB000_3100, DS = 32'h2404_0004, W3 = 32'h2405_0005;
  localparam logic [31:0] W4 = 32'h2406_0006, W5 = 32'h2407_0007, JUNK = 32'hDEAD_BEEF;

  vec_t vecs[19];

  // Random-run state
  logic [31:0] exp_cur, exp_prev;
  logic        prev_valid_m, prev_stall, busy, pend_req;
  logic [31:0] held_addr, last_pcd, last_instr;
  logic        last_valid;
  int          wait_cnt, entries;

  initial begin
    // Each row: expected outputs seen this cycle, then inputs driven for this cycle.
    vecs[0]  = mk(1, 32'h3000, 0, 32'h3000, 0,    1, 0, 1, W0,   32'h3004);
    vecs[1]  = mk(1, 32'h3004, 1, 32'h3000, W0,   1, 0, 1, W1,   32'h3008);
    vecs[2]  = mk(1, 32'h3008, 1, 32'h3004, W1,   1, 0, 1, W2,   32'h300C);
    vecs[3]  = mk(1, 32'h300C, 1, 32'h3008, W2,   0, 0, 0, 0,    32'h3010);
    vecs[4]  = mk(0, 32'h3000, 0, 32'h0,    0,    1, 0, 0, 0,    32'h3004);
    vecs[5]  = mk(1, 32'h3000, 0, 32'h3000, 0,    1, 0, 1, BR,   32'h3004);
    vecs[6]  = mk(1, 32'h3004, 1, 32'h3000, BR,   1, 0, 0, 0,    32'h3100);
    vecs[7]  = mk(1, 32'h3004, 0, 32'h3004, 0,    1, 0, 0, 0,    32'h3008);
    vecs[8]  = mk(1, 32'h3004, 0, 32'h3004, 0,    1, 0, 1, DS,   32'h3008);
    vecs[9]  = mk(1, 32'h3100, 1, 32'h3004, DS,   1, 1, 0, 0,    32'h3104);
    vecs[10] = mk(1, 32'h3100, 1, 32'h3004, DS,   1, 1, 1, W3,   32'h3104);
    vecs[11] = mk(0, 32'h3100, 1, 32'h3004, DS,   1, 1, 0, 0,    32'h3104);
    vecs[12] = mk(0, 32'h3100, 1, 32'h3004, DS,   1, 1, 1, JUNK, 32'h3104);
    vecs[13] = mk(0, 32'h3100, 1, 32'h3004, DS,   1, 0, 0, 0,    32'h3104);
    vecs[14] = mk(1, 32'h3104, 1, 32'h3100, W3,   1, 0, 0, 0,    32'h3108);
    vecs[15] = mk(1, 32'h3104, 0, 32'h3104, 0,    0, 0, 0, 0,    32'h3108);
    vecs[16] = mk(0, 32'h3000, 0, 32'h0,    0,    1, 0, 1, JUNK, 32'h3004);
    vecs[17] = mk(1, 32'h3000, 0, 32'h3000, 0,    1, 0, 1, W4,   32'h3004);
    vecs[18] = mk(1, 32'h3004, 1, 32'h3000, W4,   1, 1, 0, 0,    32'h3008);

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_F", pc_F, 32'h3000);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, valid_D}, 0);
    chk("rst_instr", instr_D, 0);
    chk("rst_pc_D", pc_D, 0);
    chk("rst_exc", {31'b0, exc_adel_D}, 0);
    reset = 1'b1;
    npc   = 32'h3004;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, valid_D}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_pc_D", i), pc_D, vecs[i].exp_pcd);
      chk($sformatf("v%0d_instr", i), instr_D, vecs[i].exp_instr);
      chk($sformatf("v%0d_exc", i), {31'b0, exc_adel_D}, 0);
      reset      = vecs[i].rst;
      stall_D    = vecs[i].stall;
      imem_ack   = vecs[i].ack;
      imem_rdata = vecs[i].rdata;
      npc        = vecs[i].npc;
    end

    // Endless stall with no ack: everything holds, request stays up.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_req", {31'b0, imem_req}, 1);
      chk("hold_pc_F", pc_F, 32'h3004);
      chk("hold_pc_D", pc_D, 32'h3000);
      chk("hold_instr", instr_D, W4);
    end

    // Misaligned next PC
    stall_D    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = W5;
    npc        = 32'h3102;
    @(negedge clk);
    chk("mis_pc_F", pc_F, 32'h3102);
`ifdef F_IFU_ALIGN_CHECK_EN
    chk("mis_req", {31'b0, imem_req}, 0);
    imem_ack = 1'b0;
    npc      = 32'h3106;
    @(negedge clk);
    chk("mis_instr", instr_D, 0);
    chk("mis_pc_D", pc_D, 32'h3102);
    chk("mis_valid", {31'b0, valid_D}, 1);
    chk("mis_exc", {31'b0, exc_adel_D}, 1);
`else
    chk("mis_req", {31'b0, imem_req}, 1);
    chk("mis_addr", imem_addr, 32'h3102);
    imem_ack   = 1'b1;
    imem_rdata = W0;
    npc        = 32'h3106;
    @(negedge clk);
    chk("mis_instr", instr_D, W0);
    chk("mis_pc_D", pc_D, 32'h3102);
    chk("mis_exc", {31'b0, exc_adel_D}, 0);
`endif

    // Randomized run against the program-order model.
    reset    = 1'b0;
    imem_ack = 1'b0;
    stall_D  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    npc   = 32'h3004;
    exp_cur      = 32'h3000;
    exp_prev     = 32'h0;
    prev_valid_m = 1'b0;
    prev_stall   = 1'b0;
    busy         = 1'b0;
    pend_req     = 1'b0;
    held_addr    = 32'h0;
    wait_cnt     = 0;
    entries      = 0;
    last_pcd     = 32'h0;
    last_instr   = 32'h0;
    last_valid   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (pend_req) begin
        chk("rnd_req_held", {31'b0, imem_req}, 1);
        chk("rnd_addr_held", imem_addr, held_addr);
      end
      if (prev_stall) begin
        chk("rnd_fd_hold_pc", pc_D, last_pcd);
        chk("rnd_fd_hold_instr", instr_D, last_instr);
        chk("rnd_fd_hold_valid", {31'b0, valid_D}, {31'b0, last_valid});
      end else if (valid_D) begin
        chk("rnd_pc_D", pc_D, exp_cur);
        chk("rnd_instr", instr_D, mem_word(exp_cur));
        entries++;
        begin
          logic [31:0] nxt;
          nxt = (prev_valid_m && is_br(mem_word(exp_prev))) ? br_tgt(mem_word(exp_prev))
                                                             : exp_cur + 32'd4;
          exp_prev     = exp_cur;
          prev_valid_m = 1'b1;
          exp_cur      = nxt;
        end
      end
      last_pcd   = pc_D;
      last_instr = instr_D;
      last_valid = valid_D;

      stall_D = ($urandom_range(0, 99) < 30);
      npc     = (valid_D && is_br(instr_D)) ? br_tgt(instr_D) : pc_F + 32'd4;
      if (imem_req) begin
        if (!busy) begin
          wait_cnt = $urandom_range(0, 3);
          busy     = 1'b1;
        end
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          busy       = 1'b0;
        end else begin
          wait_cnt--;
          imem_ack   = 1'b0;
          imem_rdata = JUNK;
        end
      end else begin
        imem_ack = 1'b0;
        busy     = 1'b0;
      end
      pend_req   = imem_req && !imem_ack;
      held_addr  = imem_addr;
      prev_stall = stall_D;
    end
    checks++;
    if (entries < 300) begin
      failures++;
      $display("FAIL rnd_throughput actual=%0d required>=300", entries);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f_ifu.md
# f_ifu

Fetch-stage instruction unit for the P5 five-stage MIPS pipeline. Holds the F-stage PC, runs a request/acknowledge handshake with instruction memory, and fills the F/D pipeline register consumed by the D stage. Its `pc_F` output feeds the D-stage next-PC logic, and it loads that logic's `npc` result back as the next fetch address. Branch delay-slot semantics are preserved across slow fetches and D-stage stalls.

## Interface
- `RESET_PC`, default 32'h0000_3000: fetch address after reset.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk`).
- `stall_D`  in  1  hazard unit: F/D register must hold.
- `npc`  in  32  next PC from D-stage next-PC logic; combinational from the current D instruction and `pc_F`.
- `pc_F`  out  32  current fetch address.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address; equals `pc_F`.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_D`  out  32  F/D instruction; 0 (nop) when not valid.
- `pc_D`  out  32  F/D PC.
- `valid_D`  out  1  F/D holds a real instruction.
- `exc_adel_D`  out  1  misaligned-fetch flag travelling with `instr_D`.

## Operation
- States:
  - S_IDLE: reset state, no request.
  - S_FETCH: `imem_req`=1, waiting for `imem_ack`.
  - S_BUF: word captured in skid register, `imem_req`=0.
- S_IDLE always goes to S_FETCH on the next edge.
- The fetch word is "available" when S_FETCH with `imem_ack`=1, or when in S_BUF.
- Accept (word available and `stall_D`=0):
  - F/D loads {word, `pc_F`, valid=1}.
  - `pc_F` loads `pend_v` ? `pend_npc` : `npc`; `pend_v` clears.
  - Next state is S_FETCH.
- Bubble (no word available and `stall_D`=0):
  - F/D loads {0, `pc_F`, valid=0}; `pc_F` holds.
  - If `valid_D`=1 and `pend_v`=0, then `pend_npc` loads `npc` and `pend_v` sets. This keeps a branch target when a branch leaves D before its delay slot arrives.
- Stall (`stall_D`=1):
  - F/D, `pc_F` and the pend registers hold.
  - In S_FETCH with `imem_ack`=1, `imem_rdata` goes into the skid register and the state goes to S_BUF.
- `imem_req` must stay high with `imem_addr` stable until `imem_ack`. An `imem_ack` outside S_FETCH is ignored.
- Zero-wait memory (ack in the same cycle as req) with no stall gives one instruction per cycle, with `imem_req` held high continuously.

## Timing
- Reset values:
  - `pc_F`=`RESET_PC`, state S_IDLE.
  - `instr_D`=0, `pc_D`=0, `valid_D`=0, `exc_adel_D`=0.
  - `pend_v`=0, `imem_req`=0.
- First request goes out in the 1st cycle after reset deasserts.
- Fetch-to-D latency:
  - Word acked in cycle n appears on `instr_D` in cycle n+1 if unstalled.
  - Otherwise it appears 1 cycle after `stall_D` drops.
- Reset asserted mid-fetch: state returns to S_IDLE and the pending ack is dropped. The memory must tolerate an abandoned request.
- Stall and ack in the same cycle: the skid capture wins; the word is never lost.
- Only one pending redirect exists. A second bubble while `pend_v`=1 does not overwrite `pend_npc`.

## Configuration
- `F_IFU_ALIGN_CHECK_EN` defined:
  - If `pc_F[1:0]`≠0, no request is issued (`imem_req`=0).
  - The word counts as available immediately, with value 0 and `exc_adel_D`=1.
  - Accept and stall rules are unchanged.
- `F_IFU_ALIGN_CHECK_EN` undefined:
  - `pc_F` is issued as-is.
  - `exc_adel_D` is tied to 0.

## Structure
- Shared `const.v` holds:
  - state encodings `IFU_IDLE`, `IFU_FETCH`, `IFU_BUF`;
  - `INSTR_NOP` (32'h0);
  - default reset PC `PC_RESET`.
- Natural sub-module: `f_skid_buf`, a one-entry 32+1-bit holding register with load/clear.
- FSM, PC and pend logic stay in `f_ifu`.

## Test plan
- Reset then zero-wait memory with no stall:
  - `imem_addr` is 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - `pc_D` trails by one cycle with `valid_D`=1.
- Branch at 0x3000 in D with `npc`=0x3100, delay slot acked with a 3-cycle wait:
  - Two bubbles reach D (`valid_D`=0).
  - Delay slot 0x3004 enters D.
  - The next `imem_addr` is 0x3100, not 0x3008.
- `stall_D`=1 held for 4 cycles with `imem_ack` in the 2nd stalled cycle:
  - State is S_BUF and `imem_req`=0.
  - The word appears on `instr_D` the cycle after `stall_D` drops.
- Reset asserted while S_FETCH waits on ack:
  - Next cycle `pc_F`=0x3000, `valid_D`=0, `imem_req`=0.
  - The late ack is ignored.
- With `F_IFU_ALIGN_CHECK_EN`, `npc`=0x3102:
  - No request is issued.
  - D receives `instr_D`=0, `pc_D`=0x3102, `exc_adel_D`=1.
- Continuous `stall_D` with `imem_ack` never asserted:
  - `pc_F` and F/D hold indefinitely.
  - `imem_req` stays 1.
